// File: rtl/slave_pkg.sv
// Shared defaults for the valid/ready stream FIFO slave.
package slave_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;
   localparam int CNT_W_DEF  = 16;
   localparam int PTR_W      = $clog2(DEPTH_DEF);

endpackage

// File: rtl/slave_fifo_mem.sv
// Storage array for the stream FIFO: synchronous write, asynchronous read, no reset.
module slave_fifo_mem
   import slave_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write port: contents are don't-care after reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/slave_stream_fifo.sv
// Valid/ready slave that buffers upstream words in a first-word-fall-through FIFO.
module slave_stream_fifo
   import slave_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        data,
   input  logic                     valid,
   output logic                     ready,
   output logic [DATA_W-1:0]        data_out,
   output logic                     valid_out,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         xfer_cnt
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int LVL_W    = PTR_BITS + 1;

   logic [PTR_BITS-1:0] wr_ptr_r;
   logic [PTR_BITS-1:0] rd_ptr_r;
   logic [LVL_W-1:0]    level_r;
   logic [LVL_W-1:0]    level_nxt_s;
   logic                ready_r;
   logic [CNT_W-1:0]    xfer_cnt_r;
   logic                push_s;
   logic                pop_s;
   logic                valid_out_s;
   logic [DATA_W-1:0]   rd_data_s;

   assign push_s      = valid & ready_r;
   assign valid_out_s = (level_r != LVL_W'(0));
   assign pop_s       = valid_out_s & out_ready;

   slave_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_BITS)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (data),
      .raddr (rd_ptr_r),
      .rdata (rd_data_s)
   );

   // Occupancy after this edge; a simultaneous push and pop cancel out.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1);
         2'b01:   level_nxt_s = level_r - LVL_W'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Pointers, occupancy, registered ready and the accepted-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {PTR_BITS{1'b0}};
         rd_ptr_r   <= {PTR_BITS{1'b0}};
         level_r    <= {LVL_W{1'b0}};
         ready_r    <= 1'b0;
         xfer_cnt_r <= {CNT_W{1'b0}};
      end else begin
         // Power-of-two depth lets the pointers wrap naturally.
         if (push_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_BITS'(1);
            xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
         end
         level_r <= level_nxt_s;
         ready_r <= (level_nxt_s != LVL_W'(DEPTH));
      end
   end

   assign ready     = ready_r;
   assign valid_out = valid_out_s;
   assign data_out  = valid_out_s ? rd_data_s : {DATA_W{1'b0}};
   assign level     = level_r;
   assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_slave_stream_fifo.sv
// Directed and random stimulus checked against a queue-based model of the FIFO slave.
module tb_slave_stream_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 4;
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic [CNT_W-1:0]  xfer_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] q[$];
   int                cnt_m   = 0;
   bit                ready_m = 1'b0;
   bit                last_push;

   always #5 clk = ~clk;

   slave_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .data_out  (data_out),
      .valid_out (valid_out),
      .out_ready (out_ready),
      .level     (level),
      .xfer_cnt  (xfer_cnt)
   );

   task automatic check_all(input string tag);
      logic [DATA_W-1:0] exp_data;
      exp_data = (q.size() != 0) ? q[0] : '0;
      n_assert++;
      assert (ready === ready_m) else begin
         n_fail++;
         $error("FAIL %s ready: got %0b expected %0b", tag, ready, ready_m);
      end
      n_assert++;
      assert (valid_out === (q.size() != 0)) else begin
         n_fail++;
         $error("FAIL %s valid_out: got %0b expected %0b", tag, valid_out, q.size() != 0);
      end
      n_assert++;
      assert (data_out === exp_data) else begin
         n_fail++;
         $error("FAIL %s data_out: got %h expected %h", tag, data_out, exp_data);
      end
      n_assert++;
      assert (level === LVL_W'(q.size())) else begin
         n_fail++;
         $error("FAIL %s level: got %0d expected %0d", tag, level, q.size());
      end
      n_assert++;
      assert (xfer_cnt === CNT_W'(cnt_m)) else begin
         n_fail++;
         $error("FAIL %s xfer_cnt: got %0d expected %0d", tag, xfer_cnt, cnt_m);
      end
   endtask

   // One clock: handshakes decided from the pre-edge model state, then checked at negedge.
   task automatic tick(input string tag);
      bit push;
      bit pop;
      push = valid && ready_m && !rst;
      pop  = (q.size() != 0) && out_ready && !rst;
      @(posedge clk);
      if (rst) begin
         q.delete();
         cnt_m   = 0;
         ready_m = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(data);
            cnt_m = (cnt_m + 1) % (1 << CNT_W);
         end
         ready_m = (q.size() != DEPTH);
      end
      last_push = push;
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; data = '0; out_ready = 1'b0;

      // Reset then idle
      repeat (3) tick("reset");
      rst = 1'b0;
      n_assert++;
      assert (ready === 1'b0) else begin
         n_fail++;
         $error("FAIL reset_release ready: got %0b expected 0", ready);
      end
      repeat (3) tick("idle");

      // Back-to-back streaming with consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1;
         data  = DATA_W'(32'h11 + i);
         tick("stream");
      end
      valid = 1'b0;
      tick("stream_end");
      n_assert++;
      assert (xfer_cnt === CNT_W'(8)) else begin
         n_fail++;
         $error("FAIL stream_cnt xfer_cnt: got %0d expected 8", xfer_cnt);
      end

      // Fill to full, offer a fifth word, then drain
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1;
         data  = DATA_W'(32'hA0 + i);
         tick("fill");
      end
      n_assert++;
      assert (level === LVL_W'(DEPTH) && ready === 1'b0) else begin
         n_fail++;
         $error("FAIL full_state level/ready: got %0d/%0b expected %0d/0", level, ready, DEPTH);
      end
      data = DATA_W'(32'hA4);
      repeat (2) tick("full_hold");
      out_ready = 1'b1;
      last_push = 1'b0;
      for (int i = 0; i < 10 && !last_push; i++) tick("full_drain");
      n_assert++;
      assert (last_push) else begin
         n_fail++;
         $error("FAIL a4_accept pushed: got 0 expected 1");
      end
      valid = 1'b0;
      repeat (6) tick("drain");

      // Simultaneous push/pop at level 2 across pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid = 1'b1;
         data  = DATA_W'(32'hB0 + i);
         tick("pre_fill");
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data = $urandom;
         tick("pushpop");
         n_assert++;
         assert (level === LVL_W'(2) && ready === 1'b1) else begin
            n_fail++;
            $error("FAIL pushpop_level level/ready: got %0d/%0b expected 2/1", level, ready);
         end
      end
      valid = 1'b0;
      repeat (3) tick("drain2");

      // Mid-operation reset at level 3
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1;
         data  = DATA_W'(32'hC0 + i);
         tick("pre_rst");
      end
      valid = 1'b0;
      rst = 1'b1;
      tick("mid_rst");
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick("post_rst");

      // Counter wrap: 17 pushes into a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         valid = 1'b1;
         data  = $urandom;
         tick("cnt_wrap");
      end
      valid = 1'b0;
      tick("cnt_end");
      n_assert++;
      assert (xfer_cnt === CNT_W'(1)) else begin
         n_fail++;
         $error("FAIL cnt_wrap xfer_cnt: got %0d expected 1", xfer_cnt);
      end

      // Random traffic; the master holds a word until it is accepted
      valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!valid || last_push) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         tick("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
